// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch front end
package fetch_pkg;
    typedef enum logic [1:0] {BOOT, RUN, FAULT} fetch_state_e;
    localparam logic [31:0] PC_INC = 32'd4;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_pkt_t;
endpackage

// File: rtl/pc_fetch.sv
// pc_fetch: PC register, fetch FSM and decode-facing fetch register
// Define PC_FETCH_PERF_EN to add fetch_count/bubble_count performance counters.
module pc_fetch
    import fetch_pkg::*;
#(
    parameter int IMEM_W = 13,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    output logic [IMEM_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_pc,
    output logic [31:0]       out_inst,
    output logic              misalign
`ifdef PC_FETCH_PERF_EN
    ,
    output logic [31:0]       fetch_count,
    output logic [31:0]       bubble_count
`endif
);
    fetch_state_e state_q, state_d;
    logic [31:0] pc_q, pc_d;
    fetch_pkt_t out_q, out_d;
    logic valid_q, valid_d;
    logic load, fire;

    assign load = !valid_q || out_ready;
    assign fire = valid_q && out_ready;

    always_comb begin
        state_d = state_q;
        pc_d = pc_q;
        out_d = out_q;
        valid_d = valid_q;
        if (state_q == BOOT) begin
            out_d.pc = pc_q;
            out_d.inst = imem_rdata;
            valid_d = 1'b1;
            pc_d = pc_q + PC_INC;
            state_d = RUN;
        end else if (state_q == RUN) begin
            // a redirect flushes the slot after any same-cycle transfer
            if (redirect_valid) begin
                valid_d = 1'b0;
                if (redirect_pc[1:0] != 2'b00)
                    state_d = FAULT;
                else
                    pc_d = redirect_pc;
            end else if (load) begin
                out_d.pc = pc_q;
                out_d.inst = imem_rdata;
                valid_d = 1'b1;
                pc_d = pc_q + PC_INC;
            end
        end else begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q <= RESET_PC;
            out_q.pc <= 32'h0;
            out_q.inst <= NOP_INST;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q <= pc_d;
            out_q <= out_d;
            valid_q <= valid_d;
        end
    end

    assign imem_addr = pc_q[IMEM_W-1:0];
    assign out_valid = valid_q;
    assign out_pc = out_q.pc;
    assign out_inst = out_q.inst;
    assign misalign = (state_q == FAULT);

`ifdef PC_FETCH_PERF_EN
    logic [31:0] fetch_q, bubble_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_q <= 32'h0;
            bubble_q <= 32'h0;
        end else begin
            if (fire)
                fetch_q <= fetch_q + 32'd1;
            if (state_q == RUN && !valid_q)
                bubble_q <= bubble_q + 32'd1;
        end
    end

    assign fetch_count = fetch_q;
    assign bubble_count = bubble_q;
`endif
endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: directed and randomized checks of pc_fetch against a behavioural model
module tb_pc_fetch;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [12:0] imem_addr;
    logic [31:0] imem_rdata;
    logic redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic out_valid;
    logic out_ready = 1'b1;
    logic [31:0] out_pc, out_inst;
    logic misalign;
`ifdef PC_FETCH_PERF_EN
    logic [31:0] fetch_count, bubble_count;
`endif

    logic [31:0] mem [2048];
    int total = 0;
    int bad = 0;
    bit armed = 0;

    // behavioural model of the fetch front end
    logic [31:0] m_pc, m_opc, m_oinst, m_fc, m_bc;
    bit m_valid, m_boot, m_fault;

    always #5 clk = ~clk;

    assign imem_rdata = mem[imem_addr[12:2]];

    pc_fetch #(.IMEM_W(13), .RESET_PC(32'h0)) dut (
        .clk(clk),
        .rst(rst),
        .imem_addr(imem_addr),
        .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_pc(out_pc),
        .out_inst(out_inst),
`ifdef PC_FETCH_PERF_EN
        .fetch_count(fetch_count),
        .bubble_count(bubble_count),
`endif
        .misalign(misalign)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_pc = 32'h0;
            m_valid = 0;
            m_opc = 32'h0;
            m_oinst = 32'h0000_0013;
            m_boot = 1;
            m_fault = 0;
            m_fc = 0;
            m_bc = 0;
        end else if (m_boot) begin
            m_opc = m_pc;
            m_oinst = mem[m_pc[12:2]];
            m_valid = 1;
            m_pc = m_pc + 4;
            m_boot = 0;
        end else if (m_fault) begin
            m_valid = 0;
        end else begin
            if (m_valid && out_ready) m_fc++;
            if (!m_valid) m_bc++;
            if (redirect_valid) begin
                m_valid = 0;
                if (redirect_pc % 4 != 0) m_fault = 1;
                else m_pc = redirect_pc;
            end else if (!m_valid || out_ready) begin
                m_opc = m_pc;
                m_oinst = mem[m_pc[12:2]];
                m_valid = 1;
                m_pc = m_pc + 4;
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("valid", {31'h0, out_valid}, {31'h0, m_valid});
            chk("misalign", {31'h0, misalign}, {31'h0, m_fault});
            chk("imem_addr", {19'h0, imem_addr}, m_pc % 8192);
            if (m_valid) begin
                chk("out_pc", out_pc, m_opc);
                chk("out_inst", out_inst, m_oinst);
            end
`ifdef PC_FETCH_PERF_EN
            chk("fetch_count", fetch_count, m_fc);
            chk("bubble_count", bubble_count, m_bc);
`endif
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic look();
        #4;
    endtask

    task automatic out_is(input string nm, input logic [31:0] pc, input logic [31:0] inst);
        look();
        chk({nm, "_v"}, {31'h0, out_valid}, 32'h1);
        chk({nm, "_pc"}, out_pc, pc);
        chk({nm, "_inst"}, out_inst, inst);
    endtask

    task automatic do_reset();
        rst = 1;
        redirect_valid = 0;
        cyc();
        rst = 0;
    endtask

    initial begin
        logic [12:0] frozen;
        for (int i = 0; i < 2048; i++) mem[i] = $urandom;
        mem[0] = 32'hA0A0_0001;
        mem[1] = 32'hB0B0_0002;
        mem[2] = 32'hC0C0_0003;
        mem[3] = 32'hD0D0_0004;
        mem[16] = 32'h1600_0016;
        mem[17] = 32'h1700_0017;
        cyc();
        armed = 1;
        cyc();
        rst = 0;
        look();
        chk("boot_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_out_inst", out_inst, 32'h0000_0013);
        chk("rst_misalign", {31'h0, misalign}, 32'h0);
        chk("rst_addr", {19'h0, imem_addr}, 32'h0);
        cyc();
        out_is("seq0", 32'h0, 32'hA0A0_0001);
        cyc();
        out_is("seq1", 32'h4, 32'hB0B0_0002);
        out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            out_is("stall", 32'h4, 32'hB0B0_0002);
            chk("stall_addr", {19'h0, imem_addr}, 32'h8);
        end
        out_ready = 1;
        cyc();
        out_is("seq2", 32'h8, 32'hC0C0_0003);
        redirect_valid = 1;
        redirect_pc = 32'h40;
        cyc();
        redirect_valid = 0;
        look();
        chk("redir_bubble", {31'h0, out_valid}, 32'h0);
        cyc();
        out_is("redir_tgt", 32'h40, 32'h1600_0016);
        cyc();
        out_is("redir_next", 32'h44, 32'h1700_0017);
        redirect_valid = 1;
        redirect_pc = 32'hFFFF_FFFC;
        cyc();
        redirect_valid = 0;
        look();
        chk("wrap_addr_hi", {19'h0, imem_addr}, 32'h1FFC);
        cyc();
        look();
        chk("wrap_addr_lo", {19'h0, imem_addr}, 32'h0);
        chk("wrap_pc_top", out_pc, 32'hFFFF_FFFC);
        cyc();
        out_is("wrap_seq", 32'h0, 32'hA0A0_0001);
        redirect_valid = 1;
        redirect_pc = 32'h42;
        cyc();
        redirect_valid = 0;
        look();
        chk("fault_flag", {31'h0, misalign}, 32'h1);
        chk("fault_valid", {31'h0, out_valid}, 32'h0);
        frozen = imem_addr;
        for (int i = 0; i < 4; i++) begin
            redirect_valid = 1'($urandom);
            redirect_pc = $urandom & 32'hFFFC;
            out_ready = 1'($urandom);
            cyc();
            look();
            chk("fault_sticky", {31'h0, misalign}, 32'h1);
            chk("fault_frozen", {19'h0, imem_addr}, {19'h0, frozen});
        end
        out_ready = 1;
        do_reset();
        look();
        chk("clr_misalign", {31'h0, misalign}, 32'h0);
        chk("clr_addr", {19'h0, imem_addr}, 32'h0);
        cyc();
        out_is("restart", 32'h0, 32'hA0A0_0001);
        do_reset();
        cyc();
        for (int i = 0; i < 3; i++) cyc();
        redirect_valid = 1;
        redirect_pc = 32'h100;
        cyc();
        redirect_valid = 0;
        for (int i = 0; i < 7; i++) cyc();
`ifdef PC_FETCH_PERF_EN
        look();
        chk("perf_fetch", fetch_count, 32'd10);
        chk("perf_bubble", bubble_count, 32'd1);
`endif
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 99) < 1);
            out_ready = ($urandom_range(0, 9) < 7);
            redirect_valid = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 19))
                0: redirect_pc = $urandom | 32'h1;
                1: redirect_pc = 32'hFFFF_FFF8;
                default: redirect_pc = $urandom & 32'hFFFF_FFFC;
            endcase
            cyc();
        end
        rst = 0;
        redirect_valid = 0;
        cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
